// File: rtl/voice_scheduler_pkg.sv
`default_nettype none
// ==== voice_scheduler_pkg : shared widths, FSM encodings, phase helper ==== Rev 1.0
package voice_scheduler_pkg;

  localparam int PHASE_W  = 22;
  localparam int STEP_W   = 20;
  localparam int ROM_AW   = 10;
  localparam int SAMPLE_W = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_OUT     = 2'd3;

  function automatic logic [PHASE_W-1:0] phase_advance(input logic [PHASE_W-1:0] phase,
                                                       input logic [STEP_W-1:0]  step);
    return phase + PHASE_W'(step);
  endfunction

endpackage
`default_nettype wire

// File: rtl/voice_scheduler_if.sv
`default_nettype none
// ==== voice_scheduler_if : codec request, voice controls, ROM port, sample out ==== Rev 1.0
interface voice_scheduler_if #(
  parameter int NUM_VOICES = 4
);
  import voice_scheduler_pkg::*;

  logic                           generate_next;
  logic [STEP_W*NUM_VOICES-1:0]   step_sizes;
  logic [NUM_VOICES-1:0]          voice_active;
  logic [ROM_AW-1:0]              rom_addr;
  logic [SAMPLE_W-1:0]            rom_data;
  logic                           sample_ready;
  logic [SAMPLE_W-1:0]            sample;
  logic                           busy;

  modport master (
    output generate_next, step_sizes, voice_active, rom_data,
    input  rom_addr, sample_ready, sample, busy
  );

  modport slave (
    input  generate_next, step_sizes, voice_active, rom_data,
    output rom_addr, sample_ready, sample, busy
  );

endinterface
`default_nettype wire

// File: rtl/voice_scheduler_quadrant_map.sv
`default_nettype none
// ==== sine_quadrant_map : phase[21:10] -> quarter-wave ROM address + negate flag ==== Rev 1.0
module sine_quadrant_map
  import voice_scheduler_pkg::*;
(
  input  wire logic [ROM_AW+1:0] i_phase_hi,
  output logic      [ROM_AW-1:0] o_rom_addr,
  output logic                   o_negate
);

  logic [ROM_AW-1:0] w_idx;

  always_comb begin
    w_idx      = i_phase_hi[ROM_AW-1:0];
    // Quadrants 1 and 3 read the quarter wave backwards.
    o_rom_addr = i_phase_hi[ROM_AW] ? ~w_idx : w_idx;
    o_negate   = i_phase_hi[ROM_AW+1];
  end

endmodule
`default_nettype wire

// File: rtl/voice_scheduler.sv
`default_nettype none
// ==== voice_scheduler : N voices share one sine ROM, mixed per codec request ==== Rev 1.0
// VOICE_SATURATE_EN: clamp the mix to 16 bits instead of shifting right by VOICE_SHIFT.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int VOICE_SHIFT = 2
)(
  input  wire logic         clk,
  input  wire logic         reset,
  voice_scheduler_if.slave  bus
);

  localparam int VW    = (VOICE_SHIFT > 0) ? VOICE_SHIFT : 1;
  localparam int ACC_W = SAMPLE_W + VOICE_SHIFT;

  logic [1:0]                r_state;
  logic [VW-1:0]             r_v;
  logic                      r_gen_prev;
  logic                      r_pending;
  logic [PHASE_W-1:0]        r_phase [NUM_VOICES];
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_negate;
  logic                      r_active;
  logic [ROM_AW-1:0]         r_rom_addr;
  logic                      r_sample_ready;
  logic [SAMPLE_W-1:0]       r_sample;

  logic                      w_edge;
  logic [STEP_W-1:0]         w_step;
  logic                      w_active;
  logic [PHASE_W-1:0]        w_new_phase;
  logic [ROM_AW-1:0]         w_map_addr;
  logic                      w_map_neg;
  logic signed [SAMPLE_W-1:0] w_rom_raw;
  logic signed [ACC_W-1:0]   w_rom_s;
  logic signed [ACC_W-1:0]   w_term;
  logic [SAMPLE_W-1:0]       w_mix;

`ifdef VOICE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] c_SAT_MIN = ACC_W'(-32'sd32768);
`endif

  always_comb begin
    w_edge      = bus.generate_next & ~r_gen_prev;
    w_step      = bus.step_sizes[r_v*STEP_W +: STEP_W];
    w_active    = bus.voice_active[r_v];
    // A silent voice parks at phase 0 so re-activation starts cleanly.
    w_new_phase = w_active ? phase_advance(r_phase[r_v], w_step) : '0;
    w_rom_raw   = bus.rom_data;
    w_rom_s     = ACC_W'(w_rom_raw);
    w_term      = r_negate ? -w_rom_s : w_rom_s;
`ifdef VOICE_SATURATE_EN
    if (r_acc > c_SAT_MAX)      w_mix = 16'h7FFF;
    else if (r_acc < c_SAT_MIN) w_mix = 16'h8000;
    else                        w_mix = r_acc[SAMPLE_W-1:0];
`else
    w_mix = SAMPLE_W'(r_acc >>> VOICE_SHIFT);
`endif
  end

  sine_quadrant_map u_map (
    .i_phase_hi (w_new_phase[PHASE_W-1:PHASE_W-ROM_AW-2]),
    .o_rom_addr (w_map_addr),
    .o_negate   (w_map_neg)
  );

  // The ROM registers the address at the end of ISSUE, so drive it live there.
  assign bus.rom_addr     = (r_state == S_ISSUE) ? w_map_addr : r_rom_addr;
  assign bus.sample_ready = r_sample_ready;
  assign bus.sample       = r_sample;
  assign bus.busy         = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_v            <= '0;
      r_gen_prev     <= 1'b0;
      r_pending      <= 1'b0;
      r_acc          <= '0;
      r_negate       <= 1'b0;
      r_active       <= 1'b0;
      r_rom_addr     <= '0;
      r_sample_ready <= 1'b0;
      r_sample       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) r_phase[i] <= '0;
    end else begin
      r_gen_prev     <= bus.generate_next;
      r_sample_ready <= 1'b0;
      if (w_edge && !r_pending) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_pending <= 1'b0;
            r_v       <= '0;
            r_acc     <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_phase[r_v] <= w_new_phase;
          r_rom_addr   <= w_map_addr;
          r_negate     <= w_map_neg;
          r_active     <= w_active;
          r_state      <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_active) r_acc <= r_acc + w_term;
          if (r_v == VW'(NUM_VOICES - 1)) begin
            r_state <= S_OUT;
          end else begin
            r_v     <= r_v + 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_OUT: begin
          r_sample       <= w_mix;
          r_sample_ready <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
